seq_magnitude_cmp: RTL and testbench

Parametrised multi-cycle magnitude comparator for operands of width WIDTH, in signed or unsigned mode. Operands are captured on a start handshake and compared CHUNK bits per cycle, MSB-first. The comparison terminates early on the first differing chunk. Registered gt/lt/eq flags are reported with a one-cycle done pulse. It sits beside the existing combinational comparators and serves datapaths where a full-width single-cycle compare is too costly in timing or area.

---
 rtl/seq_cmp_pkg.sv | 25 ++
 rtl/cmp_chunk.sv | 25 ++
 rtl/seq_magnitude_cmp.sv | 123 ++++++++++++
 tb/tb_seq_magnitude_cmp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the multi-cycle magnitude comparator.
// Chunk results use a 2-bit encoding so the top level can test "differs" cheaply.
package seq_cmp_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef logic [1:0] cmp_res_t;

   localparam cmp_res_t CMP_EQ = 2'b00;
   localparam cmp_res_t CMP_LT = 2'b01;
   localparam cmp_res_t CMP_GT = 2'b10;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Index counter width; a single-chunk compare still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
// Produces the shared 2-bit result encoding.
module cmp_chunk
   import seq_cmp_pkg::*;
#(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output cmp_res_t         res
);

   // Three-way unsigned slice compare
   always_comb begin
      res = CMP_EQ;
      if (a > b) begin
         res = CMP_GT;
      end else if (a < b) begin
         res = CMP_LT;
      end else begin
         res = CMP_EQ;
      end
   end

endmodule

// File: rtl/seq_magnitude_cmp.sv
// Multi-cycle MSB-first magnitude comparator with early termination.
// Signed operands are mapped onto unsigned order by flipping the sign bit at capture.
module seq_magnitude_cmp
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDX_W  = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1'b1) << (WIDTH - 1);

   if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "seq_magnitude_cmp: illegal WIDTH/CHUNK combination");
   end

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [IDX_W-1:0] idx_r;
   logic             busy_r;
   logic             done_r;
   logic             gt_r;
   logic             lt_r;
   logic             eq_r;

   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [WIDTH-1:0] flip_s;
   cmp_res_t         res_s;

   assign flip_s = signed_mode ? MSB_MASK : '0;

   // One-hot slice select: exactly one chunk matches the current index
   always_comb begin
      a_chunk_s = '0;
      b_chunk_s = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         a_chunk_s = a_chunk_s | ((idx_r == IDX_W'(i)) ? a_r[i*CHUNK +: CHUNK] : '0);
         b_chunk_s = b_chunk_s | ((idx_r == IDX_W'(i)) ? b_r[i*CHUNK +: CHUNK] : '0);
      end
   end

   cmp_chunk #(
      .CHUNK (CHUNK)
   ) u_cmp_chunk (
      .a   (a_chunk_s),
      .b   (b_chunk_s),
      .res (res_s)
   );

   // Control FSM, operand capture and registered result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         idx_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         gt_r    <= 1'b0;
         lt_r    <= 1'b0;
         eq_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= a ^ flip_s;
                  b_r     <= b ^ flip_s;
                  idx_r   <= LAST_IDX;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (res_s != CMP_EQ || idx_r == '0) begin
                  gt_r    <= (res_s == CMP_GT);
                  lt_r    <= (res_s == CMP_LT);
                  eq_r    <= (res_s == CMP_EQ);
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  idx_r   <= idx_r - IDX_W'(1'b1);
                  done_r  <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign gt   = gt_r;
   assign lt   = lt_r;
   assign eq   = eq_r;

endmodule

// File: tb/tb_seq_magnitude_cmp.sv
// Bench for seq_magnitude_cmp: three configurations (8/2, 3/1, 3/3) checked every cycle
// against a latency/result model derived from plain arithmetic.
module tb_seq_magnitude_cmp;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st0 = 1'b0, sm0 = 1'b0;
   logic [7:0] a0 = '0, b0 = '0;
   logic       busy0, done0, gt0, lt0, eq0;
   logic       st1 = 1'b0, sm1 = 1'b0;
   logic [2:0] a1 = '0, b1 = '0;
   logic       busy1, done1, gt1, lt1, eq1;
   logic       st2 = 1'b0, sm2 = 1'b0;
   logic [2:0] a2 = '0, b2 = '0;
   logic       busy2, done2, gt2, lt2, eq2;

   seq_magnitude_cmp #(.WIDTH(8), .CHUNK(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(st0), .signed_mode(sm0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0));
   seq_magnitude_cmp #(.WIDTH(3), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .signed_mode(sm1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1));
   seq_magnitude_cmp #(.WIDTH(3), .CHUNK(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(st2), .signed_mode(sm2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2));

   int checks = 0;
   int failures = 0;

   logic m_busy [3];
   logic m_done [3];
   logic m_gt [3];
   logic m_lt [3];
   logic m_eq [3];
   logic p_gt [3];
   logic p_lt [3];
   logic p_eq [3];
   int   m_rem [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 1'b0; m_done[i] = 1'b0;
         m_gt[i] = 1'b0; m_lt[i] = 1'b0; m_eq[i] = 1'b0;
         m_rem[i] = 0;
      end
   endtask

   // Expected behaviour at one clock edge, given the inputs sampled there
   task automatic model_edge(input int id, input logic st, input logic sm,
                             input int av, input int bv, input int w, input int c);
      int sa, sb, lat;
      bit found;
      if (m_busy[id]) begin
         m_rem[id]--;
         if (m_rem[id] == 0) begin
            m_busy[id] = 1'b0; m_done[id] = 1'b1;
            m_gt[id] = p_gt[id]; m_lt[id] = p_lt[id]; m_eq[id] = p_eq[id];
         end else begin
            m_done[id] = 1'b0;
         end
      end else begin
         m_done[id] = 1'b0;
         if (st) begin
            sa = av; sb = bv;
            if (sm && av >= (1 << (w - 1))) sa = av - (1 << w);
            if (sm && bv >= (1 << (w - 1))) sb = bv - (1 << w);
            p_gt[id] = (sa > sb); p_lt[id] = (sa < sb); p_eq[id] = (sa == sb);
            lat = w / c;
            found = 1'b0;
            for (int i = 1; i <= w / c; i++) begin
               if (!found && (((av >> (w - c * i)) % (1 << c)) != ((bv >> (w - c * i)) % (1 << c)))) begin
                  lat = i;
                  found = 1'b1;
               end
            end
            m_busy[id] = 1'b1;
            m_rem[id]  = lat;
         end
      end
   endtask

   task automatic check_dut(input int id, input logic bu, input logic dn,
                            input logic g, input logic l, input logic e);
      chk($sformatf("d%0d_busy", id), bu, m_busy[id]);
      chk($sformatf("d%0d_done", id), dn, m_done[id]);
      chk($sformatf("d%0d_gt", id), g, m_gt[id]);
      chk($sformatf("d%0d_lt", id), l, m_lt[id]);
      chk($sformatf("d%0d_eq", id), e, m_eq[id]);
   endtask

   task automatic check_all();
      check_dut(0, busy0, done0, gt0, lt0, eq0);
      check_dut(1, busy1, done1, gt1, lt1, eq1);
      check_dut(2, busy2, done2, gt2, lt2, eq2);
   endtask

   task automatic cycle();
      model_edge(0, st0, sm0, int'(a0), int'(b0), 8, 2);
      model_edge(1, st1, sm1, int'(a1), int'(b1), 3, 1);
      model_edge(2, st2, sm2, int'(a2), int'(b2), 3, 3);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // One operation on the 8-bit instance; returns the observed start-to-done latency
   task automatic go0(input logic sm, input logic [7:0] av, input logic [7:0] bv, output int lat);
      st0 = 1'b1; sm0 = sm; a0 = av; b0 = bv;
      cycle();
      st0 = 1'b0;
      lat = 0;
      do begin
         a0 = 8'($urandom); b0 = 8'($urandom); sm0 = 1'($urandom);
         cycle();
         lat++;
      end while (!done0 && lat < 12);
   endtask

   task automatic expect0(input string tag, input int lat, input int exp_lat,
                          input logic g, input logic l, input logic e);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_gt"}, gt0, g);
      chk({tag, "_lt"}, lt0, l);
      chk({tag, "_eq"}, eq0, e);
   endtask

   initial begin
      int lat;
      model_reset();
      #2;
      check_all();
      #1 rst_n = 1'b1;

      go0(1'b0, 8'h80, 8'h7F, lat); expect0("t1", lat, 1, 1'b1, 1'b0, 1'b0);
      go0(1'b0, 8'h34, 8'h37, lat); expect0("t2a", lat, 4, 1'b0, 1'b1, 1'b0);
      go0(1'b0, 8'hA5, 8'hA5, lat); expect0("t2b", lat, 4, 1'b0, 1'b0, 1'b1);
      go0(1'b1, 8'h80, 8'h01, lat); expect0("t3a", lat, 1, 1'b0, 1'b1, 1'b0);
      go0(1'b0, 8'h80, 8'h01, lat); expect0("t3b", lat, 1, 1'b1, 1'b0, 1'b0);
      go0(1'b1, 8'hFF, 8'hFE, lat); expect0("t3c", lat, 4, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("t3_done_pulse", done0, 1'b0);

      // Start held high with operands changing every cycle
      st0 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         a0 = 8'($urandom); b0 = 8'($urandom); sm0 = 1'($urandom);
      end
      st0 = 1'b0;
      for (int i = 0; i < 6; i++) cycle();

      // Asynchronous reset in the middle of an operation
      st0 = 1'b1; sm0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
      cycle();
      st0 = 1'b0;
      cycle();
      cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      #3 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      go0(1'b0, 8'h12, 8'h13, lat); expect0("t5", lat, 4, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         go0(1'($urandom), 8'($urandom), 8'($urandom), lat);
      end

      // Exhaustive sweep of the 3-bit configurations
      for (int sm = 0; sm < 2; sm++) begin
         for (int av = 0; av < 8; av++) begin
            for (int bv = 0; bv < 8; bv++) begin
               st1 = 1'b1; st2 = 1'b1;
               sm1 = 1'(sm); sm2 = 1'(sm);
               a1 = 3'(av); b1 = 3'(bv); a2 = 3'(av); b2 = 3'(bv);
               cycle();
               st1 = 1'b0; st2 = 1'b0;
               for (int c = 0; c < 6 && (m_busy[1] || m_busy[2]); c++) begin
                  a1 = 3'($urandom); b1 = 3'($urandom); a2 = 3'($urandom); b2 = 3'($urandom);
                  sm1 = 1'($urandom); sm2 = 1'($urandom);
                  cycle();
               end
            end
         end
      end
      for (int i = 0; i < 3; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
